// File: rtl/soc_bus_fabric.sv
// Single-cycle-response bus fabric: byte-addressed SRAM, a status word, UART/SPI mailboxes and a sticky panic.
// The SRAM powers up as all zeros.
module soc_bus_fabric #(
  parameter int SRAM_SIZE = 65536
) (
  input  logic        r_clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        core_trap,
  output logic        core_clk_en,
  input  logic [31:0] uart_rx_data,
  input  logic        uart_wait,
  output logic [31:0] uart_tx_data,
  output logic        uart_we,
  output logic        uart_re,
  input  logic [31:0] spi_rx_data,
  input  logic        spi_wait,
  output logic [31:0] spi_tx_data,
  output logic        spi_ex,
  output logic        spi_ack,
  input  logic        recovery,
  input  logic        rng,
  output logic        panic
);

  localparam int          AW      = (SRAM_SIZE > 1) ? $clog2(SRAM_SIZE) : 1;
  localparam logic [AW:0] SIZE_W  = (AW + 1)'(SRAM_SIZE);
  localparam logic [24:0] SIZE_25 = 25'(SRAM_SIZE);

  localparam logic [31:0] ADDR_STATUS = 32'h0100_0000;
  localparam logic [31:0] ADDR_UART   = 32'h0100_0004;
  localparam logic [31:0] ADDR_SPI    = 32'h0100_0008;

  typedef enum logic [2:0] {
    T_SRAM,
    T_STATUS,
    T_UART,
    T_SPI,
    T_BAD
  } target_e;

  logic [7:0] r_mem [SRAM_SIZE] = '{default: 8'h00};

  logic          r_mem_ready;
  logic [31:0]   r_mem_rdata;
  logic          r_panic;
  logic [31:0]   r_uart_tx_data;
  logic          r_uart_we;
  logic          r_uart_re;
  logic [31:0]   r_spi_tx_data;
  logic          r_spi_ex;
  logic          r_spi_ack;

  target_e       w_target;
  logic          w_accept;
  logic          w_is_write;
  logic [AW-1:0] w_idx [4];
  logic [31:0]   w_sram_word;
  logic [31:0]   w_status;

  // Wrap a byte index that has stepped past the top of the SRAM back to its base.
  function automatic logic [AW-1:0] wrap_idx(input logic [AW:0] sum);
    return (sum >= SIZE_W) ? AW'(sum - SIZE_W) : AW'(sum);
  endfunction

  assign w_accept   = mem_valid & ~r_mem_ready & ~r_panic;
  assign w_is_write = |mem_wstrb;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    w_target = T_BAD;
    if (mem_addr[31:24] == 8'h00 && {1'b0, mem_addr[23:0]} < SIZE_25) w_target = T_SRAM;
    else if (mem_addr == ADDR_STATUS)                                 w_target = T_STATUS;
    else if (mem_addr == ADDR_UART)                                   w_target = T_UART;
    else if (mem_addr == ADDR_SPI)                                    w_target = T_SPI;
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_idx[n] = wrap_idx({1'b0, mem_addr[AW-1:0]} + (AW + 1)'(n));
    end
  end

  assign w_sram_word = {r_mem[w_idx[3]], r_mem[w_idx[2]], r_mem[w_idx[1]], r_mem[w_idx[0]]};

  assign w_status = {26'd0,
                     spi_wait,
                     spi_rx_data != 32'hFFFF_FFFF,
                     rng,
                     recovery,
                     uart_wait,
                     uart_rx_data != 32'hFFFF_FFFF};

  // NOTE: the SRAM has no reset branch; gating the write with rst_n keeps an aborted access harmless.
  always_ff @(posedge r_clk) begin
    if (rst_n && w_accept && w_target == T_SRAM) begin
      for (int n = 0; n < 4; n++) begin
        if (mem_wstrb[n]) r_mem[w_idx[n]] <= mem_wdata[8*n +: 8];
      end
    end
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge r_clk) begin
    if (!rst_n) begin
      r_mem_ready    <= 1'b0;
      r_mem_rdata    <= '0;
      r_panic        <= 1'b0;
      r_uart_tx_data <= '0;
      r_uart_we      <= 1'b0;
      r_uart_re      <= 1'b0;
      r_spi_tx_data  <= '0;
      r_spi_ex       <= 1'b0;
      r_spi_ack      <= 1'b0;
    end else begin
      r_mem_ready <= 1'b0;
      r_uart_we   <= 1'b0;
      r_uart_re   <= 1'b0;
      r_spi_ex    <= 1'b0;
      r_spi_ack   <= 1'b0;
      if (core_trap) r_panic <= 1'b1;
      if (w_accept) begin
        r_mem_ready <= 1'b1;
        unique case (w_target)
          T_SRAM: begin
            if (!w_is_write) r_mem_rdata <= w_sram_word;
          end
          T_STATUS: begin
            if (w_is_write) r_panic     <= 1'b1;
            else            r_mem_rdata <= w_status;
          end
          T_UART: begin
            if (w_is_write) begin
              if (!uart_wait) begin
                r_uart_tx_data <= mem_wdata;
                r_uart_we      <= 1'b1;
              end
            end else begin
              r_mem_rdata <= uart_rx_data;
              r_uart_re   <= 1'b1;
            end
          end
          T_SPI: begin
            if (w_is_write) begin
              if (!spi_wait) begin
                r_spi_tx_data <= mem_wdata;
                r_spi_ex      <= 1'b1;
              end
            end else begin
              r_mem_rdata <= spi_rx_data;
              r_spi_ack   <= 1'b1;
            end
          end
          default: r_panic <= 1'b1;
        endcase
      end
    end
  end

  assign mem_ready    = r_mem_ready;
  assign mem_rdata    = r_mem_rdata;
  assign panic        = r_panic;
  assign core_clk_en  = ~r_panic;
  assign uart_tx_data = r_uart_tx_data;
  assign uart_we      = r_uart_we;
  assign uart_re      = r_uart_re;
  assign spi_tx_data  = r_spi_tx_data;
  assign spi_ex       = r_spi_ex;
  assign spi_ack      = r_spi_ack;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Scoreboard bench for soc_bus_fabric: stimulus queues expected responses, a negedge monitor checks each mem_ready.
module tb_soc_bus_fabric;

  localparam int SRAM_SIZE = 65536;

  logic        r_clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        core_trap;
  logic        core_clk_en;
  logic [31:0] uart_rx_data;
  logic        uart_wait;
  logic [31:0] uart_tx_data;
  logic        uart_we;
  logic        uart_re;
  logic [31:0] spi_rx_data;
  logic        spi_wait;
  logic [31:0] spi_tx_data;
  logic        spi_ex;
  logic        spi_ack;
  logic        recovery;
  logic        rng;
  logic        panic;

  soc_bus_fabric #(.SRAM_SIZE(SRAM_SIZE)) dut (
    .r_clk        (r_clk),
    .rst_n        (rst_n),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata),
    .core_trap    (core_trap),
    .core_clk_en  (core_clk_en),
    .uart_rx_data (uart_rx_data),
    .uart_wait    (uart_wait),
    .uart_tx_data (uart_tx_data),
    .uart_we      (uart_we),
    .uart_re      (uart_re),
    .spi_rx_data  (spi_rx_data),
    .spi_wait     (spi_wait),
    .spi_tx_data  (spi_tx_data),
    .spi_ex       (spi_ex),
    .spi_ack      (spi_ack),
    .recovery     (recovery),
    .rng          (rng),
    .panic        (panic)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    string       name;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic [3:0]  strobes;   // {uart_we, uart_re, spi_ex, spi_ack}
    logic [31:0] uart_tx;
    logic [31:0] spi_tx;
  } exp_t;

  exp_t        sb_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] exp_uart_tx = '0;
  logic [31:0] exp_spi_tx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every mem_ready pops one expected response; strobes must be quiet otherwise.
  always @(negedge r_clk) begin
    if (mem_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected mem_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.chk_rdata) check({e.name, " rdata"}, mem_rdata, e.rdata);
        check({e.name, " strobes"}, {28'd0, uart_we, uart_re, spi_ex, spi_ack}, {28'd0, e.strobes});
        check({e.name, " uart_tx"}, uart_tx_data, e.uart_tx);
        check({e.name, " spi_tx"}, spi_tx_data, e.spi_tx);
      end
    end else begin
      check("idle strobes", {28'd0, uart_we, uart_re, spi_ex, spi_ack}, 32'd0);
    end
  end

  // Called one time unit after a rising edge; returns at the same phase two edges later.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                     input string name, input logic chk, input logic [31:0] rd, input logic [3:0] strobes);
    exp_t e;
    e.name      = name;
    e.chk_rdata = chk;
    e.rdata     = rd;
    e.strobes   = strobes;
    e.uart_tx   = exp_uart_tx;
    e.spi_tx    = exp_spi_tx;
    sb_q.push_back(e);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    @(posedge r_clk); #1;
    check({name, " ready latency"}, {31'd0, mem_ready}, 32'd1);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge r_clk); #1;
    check({name, " ready one cycle"}, {31'd0, mem_ready}, 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge r_clk); #1;
    rst_n = 1'b1;
    exp_rdata   = '0;
    exp_uart_tx = '0;
    exp_spi_tx  = '0;
    check("reset panic", {31'd0, panic}, 32'd0);
    check("reset clk_en", {31'd0, core_clk_en}, 32'd1);
    check("reset rdata", mem_rdata, 32'd0);
    check("reset uart_tx", uart_tx_data, 32'd0);
    check("reset spi_tx", spi_tx_data, 32'd0);
  endtask

  task automatic check_panicked(input string name);
    check({name, " panic"}, {31'd0, panic}, 32'd1);
    check({name, " clk_en"}, {31'd0, core_clk_en}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    mem_valid    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    core_trap    = 1'b0;
    uart_rx_data = 32'hFFFF_FFFF;
    uart_wait    = 1'b0;
    spi_rx_data  = 32'hFFFF_FFFF;
    spi_wait     = 1'b0;
    recovery     = 1'b0;
    rng          = 1'b0;
    repeat (2) @(posedge r_clk);
    #1;
    check("init ready", {31'd0, mem_ready}, 32'd0);
    pulse_reset();

    // SRAM: word write, strobed write, aligned/unaligned/wrapping reads
    bus(32'h0000_0000, 32'h1122_3344, 4'hF, "sram word wr", 1'b1, exp_rdata, 4'h0);
    bus(32'h0000_0100, 32'hA1B2_C3D4, 4'h5, "sram byte wr", 1'b1, exp_rdata, 4'h0);
    bus(32'h0000_0100, 32'h0, 4'h0, "sram rd 100", 1'b1, 32'h00B2_00D4, 4'h0);
    bus(32'h0000_0102, 32'h0, 4'h0, "sram rd 102", 1'b1, 32'h0000_00B2, 4'h0);
    bus(32'h0000_FFFE, 32'hDDCC_BBAA, 4'hF, "sram wrap wr", 1'b1, 32'h0000_00B2, 4'h0);
    bus(32'h0000_0000, 32'h0, 4'h0, "sram rd 0", 1'b1, 32'h1122_DDCC, 4'h0);
    bus(32'h0000_FFFE, 32'h0, 4'h0, "sram rd FFFE", 1'b1, 32'hDDCC_BBAA, 4'h0);

    // Status word
    uart_rx_data = 32'h0000_0041; uart_wait = 1'b1; recovery = 1'b1; rng = 1'b0;
    spi_rx_data  = 32'hFFFF_FFFF; spi_wait  = 1'b0;
    bus(32'h0100_0000, 32'h0, 4'h0, "status A", 1'b1, 32'h0000_0007, 4'h0);
    uart_rx_data = 32'hFFFF_FFFF; uart_wait = 1'b0; recovery = 1'b0; rng = 1'b1;
    spi_rx_data  = 32'h0000_003C; spi_wait  = 1'b1;
    bus(32'h0100_0000, 32'h0, 4'h0, "status B", 1'b1, 32'h0000_0038, 4'h0);
    exp_rdata = 32'h0000_0038;

    // UART: write, busy-drop, read
    uart_wait = 1'b0; exp_uart_tx = 32'h0000_0055;
    bus(32'h0100_0004, 32'h0000_0055, 4'hF, "uart wr", 1'b1, exp_rdata, 4'b1000);
    uart_wait = 1'b1;
    bus(32'h0100_0004, 32'h0000_00AA, 4'hF, "uart busy wr", 1'b1, exp_rdata, 4'b0000);
    uart_rx_data = 32'h0000_0041;
    bus(32'h0100_0004, 32'h0, 4'h0, "uart rd", 1'b1, 32'h0000_0041, 4'b0100);
    exp_rdata = 32'h0000_0041;

    // SPI: exchange, busy-drop, read
    spi_wait = 1'b0; exp_spi_tx = 32'h0000_00A5;
    bus(32'h0100_0008, 32'h0000_00A5, 4'h1, "spi wr", 1'b1, exp_rdata, 4'b0010);
    spi_wait = 1'b1;
    bus(32'h0100_0008, 32'h0000_0077, 4'hF, "spi busy wr", 1'b1, exp_rdata, 4'b0000);
    spi_rx_data = 32'h0000_003C;
    bus(32'h0100_0008, 32'h0, 4'h0, "spi rd", 1'b1, 32'h0000_003C, 4'b0001);

    // Panic from an unmapped address; later requests must be ignored
    bus(32'h0200_0000, 32'h0, 4'h0, "bad addr rd", 1'b0, 32'h0, 4'h0);
    check_panicked("bad addr");
    mem_valid = 1'b1; mem_addr = 32'h0000_0100; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge r_clk); #1;
      check("panic ignores request", {31'd0, mem_ready}, 32'd0);
    end
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    pulse_reset();
    bus(32'h0000_0100, 32'h0, 4'h0, "sram kept over reset", 1'b1, 32'h00B2_00D4, 4'h0);

    // Panic from core_trap
    core_trap = 1'b1;
    @(posedge r_clk); #1;
    core_trap = 1'b0;
    check_panicked("core_trap");
    @(posedge r_clk); #1;
    check_panicked("core_trap sticky");
    pulse_reset();

    // Panic from a status-word write
    bus(32'h0100_0000, 32'h1, 4'hF, "status wr", 1'b0, 32'h0, 4'h0);
    check_panicked("status wr");
    pulse_reset();

    // Reset while a write is being accepted aborts it
    bus(32'h0000_0010, 32'h0000_0012, 4'h1, "sram wr 10", 1'b1, 32'h0, 4'h0);
    mem_valid = 1'b1; mem_addr = 32'h0000_0010; mem_wdata = 32'h0000_0099; mem_wstrb = 4'h1;
    rst_n = 1'b0;
    @(posedge r_clk); #1;
    check("abort ready", {31'd0, mem_ready}, 32'd0);
    mem_valid = 1'b0; mem_wstrb = 4'h0; rst_n = 1'b1;
    bus(32'h0000_0010, 32'h0, 4'h0, "sram rd 10", 1'b1, 32'h0000_0012, 4'h0);

    repeat (3) @(posedge r_clk);
    #1;
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
